// File: rtl/riscv_pkg.sv
// Shared RV32I fetch-side types and constants.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  // One buffered fetch result: the word and the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential next word address; wraps naturally at 32 bits.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetch entries with flush; head is a registered entry.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: producer must respect credits; push is ignored when full without a pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // Full-with-pop is legal: the write slot is the one being read out this cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer, occupancy and storage update; flush discards everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC ownership, credit-limited imem reads, buffered (pc, instr) to decode.
// Latency: a word is presented to decode the cycle after its rvalid; redirects take effect next cycle.
// Backpressure: decode stalls via instr_ready_i; requests stop once FIFO + in-flight reach DEPTH.
// Optional FETCH_MISALIGN_EN: misaligned redirect targets raise misalign_o and halt fetching.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] stale;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits_used;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          req_fire;
  logic          halted;
  logic [31:0]   target;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

`ifdef FETCH_MISALIGN_EN
  assign target = redirect_pc_i;

  // A misaligned redirect parks the fetcher until software/branch unit steers it to an aligned PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (redirect_i) begin
      halted <= |redirect_pc_i[1:0];
    end
  end

  assign misalign_o = halted;
`else
  logic unused_redirect_lo;

  // Without misalignment reporting the low bits are simply ignored.
  assign target             = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lo = ^redirect_pc_i[1:0];
  assign halted             = 1'b0;
  assign misalign_o         = 1'b0;
`endif

  // Credits cover both buffered words and words still owed by imem, so responses never overflow.
  assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding};
  // rst_n gating keeps the request low while reset is held.
  assign imem_req_o   = rst_n && !redirect_i && !halted && (credits_used < DEPTH_W);
  assign imem_addr_o  = pc;
  assign req_fire     = imem_req_o && imem_gnt_i;
  assign out_nxt      = outstanding + CW'(req_fire) - CW'(imem_rvalid_i);

  // Responses to wrong-path requests (stale, or arriving during a redirect) are dropped.
  assign fifo_push  = imem_rvalid_i && (stale == '0) && !redirect_i && (!fifo_full || fifo_pop);
  assign push_entry = '{pc: resp_pc, instr: imem_rdata_i};
  assign fifo_pop   = instr_valid_o && instr_ready_i;

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = head.instr;
  assign pc_o          = head.pc;

  // PC, response PC and in-flight bookkeeping; a redirect marks everything in flight as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_i) begin
        pc      <= target;
        resp_pc <= target;
        stale   <= out_nxt;
      end else begin
        if (req_fire) begin
          pc <= pc_next(pc);
        end
        if (imem_rvalid_i) begin
          if (stale != '0) begin
            stale <= stale - CW'(1);
          end else begin
            resp_pc <= pc_next(resp_pc);
          end
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .flush      (redirect_i),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

endmodule
